// File: rtl/fdtd_ez_sequencer.sv
// FDTD Ez sequencer: drives the Hy sweep, the Ez sweep and the source load for a
// programmed number of time steps. The strobes are mutually exclusive, so the
// {calc_Ez_en, calc_src_en} selector code 2'b11 can never occur.
module fdtd_ez_sequencer #(
    parameter int unsigned CELL_NUM   = 200,
    parameter int unsigned SRC_POS    = 100,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned STEP_WIDTH = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [STEP_WIDTH-1:0] step_num_i,
    input  logic                  calc_ready_i,
    output logic                  calc_Hy_en_o,
    output logic                  calc_Ez_en_o,
    output logic                  calc_src_en_o,
    output logic [ADDR_WIDTH-1:0] cell_addr_o,
    output logic [STEP_WIDTH-1:0] step_cnt_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(CELL_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] SrcAddr  = ADDR_WIDTH'(SRC_POS);

    typedef enum logic [2:0] {StIdle, StCalcH, StCalcE, StLoadSrc, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [STEP_WIDTH-1:0] num_q, num_d;
    logic                  hy_q, hy_d;
    logic                  ez_q, ez_d;
    logic                  src_q, src_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Next-state logic; output flops are a decode of the next state so every
    // output comes straight from a register.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step_d  = step_q;
        num_d   = num_q;

        unique case (state_q)
            StIdle: begin
                if (start_i && !abort_i) begin
                    step_d = '0;
                    addr_d = '0;
                    if (step_num_i != '0) begin
                        num_d   = step_num_i;
                        state_d = StCalcH;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StCalcH: begin
                if (calc_ready_i) begin
                    if (addr_q == LastAddr) begin
                        addr_d  = '0;
                        state_d = StCalcE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StCalcE: begin
                if (calc_ready_i) begin
                    if (addr_q == LastAddr) begin
                        addr_d  = SrcAddr;
                        state_d = StLoadSrc;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StLoadSrc: begin
                if (calc_ready_i) begin
                    if (step_q == num_q - STEP_WIDTH'(1)) begin
                        state_d = StDone;
                    end else begin
                        step_d  = step_q + 1'b1;
                        addr_d  = '0;
                        state_d = StCalcH;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort overrides any progress made above.
        if (abort_i && state_q != StIdle) begin
            state_d = StIdle;
            addr_d  = '0;
            step_d  = '0;
        end

        hy_d   = (state_d == StCalcH);
        ez_d   = (state_d == StCalcE);
        src_d  = (state_d == StLoadSrc);
        busy_d = hy_d || ez_d || src_d;
        done_d = (state_d == StDone);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            addr_q  <= '0;
            step_q  <= '0;
            num_q   <= '0;
            hy_q    <= 1'b0;
            ez_q    <= 1'b0;
            src_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
            num_q   <= num_d;
            hy_q    <= hy_d;
            ez_q    <= ez_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign calc_Hy_en_o  = hy_q;
    assign calc_Ez_en_o  = ez_q;
    assign calc_src_en_o = src_q;
    assign cell_addr_o   = addr_q;
    assign step_cnt_o    = step_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_fdtd_ez_sequencer.sv
// Scoreboard bench for fdtd_ez_sequencer with an 8-cell grid and source at cell 3.
module tb_fdtd_ez_sequencer;

    localparam int Cells = 8;
    localparam int Src   = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] step_num_i = '0;
    logic        calc_ready_i = 1'b1;
    logic        calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, busy_o, done_o;
    logic [7:0]  cell_addr_o;
    logic [15:0] step_cnt_o;

    fdtd_ez_sequencer #(
        .CELL_NUM  (Cells),
        .SRC_POS   (Src),
        .ADDR_WIDTH(8),
        .STEP_WIDTH(16)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .step_num_i   (step_num_i),
        .calc_ready_i (calc_ready_i),
        .calc_Hy_en_o (calc_Hy_en_o),
        .calc_Ez_en_o (calc_Ez_en_o),
        .calc_src_en_o(calc_src_en_o),
        .cell_addr_o  (cell_addr_o),
        .step_cnt_o   (step_cnt_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          cy;
        logic        hy, ez, src, dn;
        logic [7:0]  addr;
        logic [15:0] step;
        bit          chk_step;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stall_lo = -1;
    int   stall_hi = -2;

    function automatic bit stalled(int c);
        return (c >= stall_lo) && (c <= stall_hi);
    endfunction

    function automatic void push_e(int cy, int kind, int addr, int step, bit chk_step);
        exp_t e;
        e.cy       = cy;
        e.hy       = (kind == 0);
        e.ez       = (kind == 1);
        e.src      = (kind == 2);
        e.dn       = (kind == 3);
        e.addr     = 8'(addr);
        e.step     = 16'(step);
        e.chk_step = chk_step;
        exp_q.push_back(e);
    endfunction

    // Reference schedule: Hy 0..7, Ez 0..7, src@3 per step, stalls hold the item.
    // max_items >= 0 truncates the run (abort/reset) and suppresses done.
    function automatic void gen_run(int base, int n, int max_items);
        int c = base + 1;
        int k = 0;
        for (int s = 0; s < n; s++) begin
            for (int ph = 0; ph < 3; ph++) begin
                for (int a = 0; a < ((ph < 2) ? Cells : 1); a++) begin
                    if (max_items >= 0 && k >= max_items) return;
                    while (stalled(c)) begin
                        push_e(c, ph, (ph == 2) ? Src : a, s, 1'b1);
                        c++;
                    end
                    push_e(c, ph, (ph == 2) ? Src : a, s, 1'b1);
                    c++;
                    k++;
                end
            end
        end
        if (max_items < 0) push_e(c, 3, 0, (n > 0) ? n - 1 : 0, n > 0);
    endfunction

    // Monitor: pops one expectation per cycle in which the DUT shows activity.
    always @(negedge CLK) begin
        exp_t e;
        logic ok;
        if (cyc >= 2) begin
            n_chk++;
            if (int'(calc_Hy_en_o) + int'(calc_Ez_en_o) + int'(calc_src_en_o) > 1) begin
                n_fail++;
                $display("FAIL onehot cyc=%0d got hy=%b ez=%b src=%b want at most one",
                         cyc, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o);
            end
            if (calc_Hy_en_o || calc_Ez_en_o || calc_src_en_o || done_o || busy_o) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected cyc=%0d got hy=%b ez=%b src=%b done=%b busy=%b addr=%0d want no activity",
                             cyc, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, done_o, busy_o,
                             cell_addr_o);
                end else begin
                    e  = exp_q.pop_front();
                    ok = (cyc == e.cy) && (calc_Hy_en_o == e.hy) && (calc_Ez_en_o == e.ez) &&
                         (calc_src_en_o == e.src) && (done_o == e.dn) && (busy_o == !e.dn) &&
                         (e.dn || cell_addr_o == e.addr) &&
                         (!e.chk_step || step_cnt_o == e.step);
                    if (!ok) begin
                        n_fail++;
                        $display("FAIL event got cyc=%0d hy=%b ez=%b src=%b done=%b busy=%b addr=%0d step=%0d want cyc=%0d hy=%b ez=%b src=%b done=%b busy=%b addr=%0d step=%0d",
                                 cyc, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, done_o, busy_o,
                                 cell_addr_o, step_cnt_o, e.cy, e.hy, e.ez, e.src, e.dn, !e.dn,
                                 e.addr, e.step);
                    end
                end
            end
        end
    end

    // Ready driver follows the stall window.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            calc_ready_i = !stalled(cyc);
        end
    end

    task automatic next_cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) next_cyc();
    endtask

    task automatic check_zero(string name);
        n_chk++;
        if (calc_Hy_en_o || calc_Ez_en_o || calc_src_en_o || busy_o || done_o ||
            cell_addr_o != 0 || step_cnt_o != 0) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got hy=%b ez=%b src=%b busy=%b done=%b addr=%0d step=%0d want all 0",
                     name, cyc, calc_Hy_en_o, calc_Ez_en_o, calc_src_en_o, busy_o, done_o,
                     cell_addr_o, step_cnt_o);
        end
    endtask

    task automatic start_run(input int n, input int max_items, output int base);
        base = cyc;
        gen_run(base, n, max_items);
        start_i    = 1'b1;
        step_num_i = 16'(n);
        next_cyc();
        start_i = 1'b0;
    endtask

    task automatic drain(string name);
        int k = 0;
        while (exp_q.size() != 0 && k < 300) begin
            next_cyc();
            k++;
        end
        repeat (3) next_cyc();
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain got %0d pending events want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        int base;
        wait_until(2);
        check_zero("reset");
        RST = 1'b0;

        // Nominal N=2 run started at cycle 10.
        wait_until(10);
        start_run(2, -1, base);
        drain("nominal");

        // Same run with ready low for three cycles during Hy address 3.
        stall_lo = cyc + 4;
        stall_hi = cyc + 6;
        start_run(2, -1, base);
        drain("stall");
        stall_lo = -1;
        stall_hi = -2;

        // Zero steps: done only.
        start_run(0, -1, base);
        drain("zero");

        // Abort while Ez address 5 of step 0 is shown.
        start_run(2, 14, base);
        wait_until(base + 14);
        abort_i = 1'b1;
        next_cyc();
        abort_i = 1'b0;
        check_zero("abort");
        drain("abort");
        start_run(2, -1, base);
        drain("restart");

        // Abort together with start in idle: nothing happens.
        abort_i    = 1'b1;
        start_i    = 1'b1;
        step_num_i = 16'd2;
        next_cyc();
        abort_i = 1'b0;
        start_i = 1'b0;
        drain("abort_start");

        // Start mid-run with another step count is ignored.
        start_run(2, -1, base);
        wait_until(base + 20);
        start_i    = 1'b1;
        step_num_i = 16'd5;
        next_cyc();
        start_i = 1'b0;
        drain("midstart");

        // Reset during the first source load.
        start_run(2, 17, base);
        wait_until(base + 17);
        RST = 1'b1;
        next_cyc();
        RST = 1'b0;
        check_zero("rst_mid");
        drain("rst_mid");
        start_run(1, -1, base);
        drain("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fdtd_ez_sequencer.md
# fdtd_ez_sequencer

Control-side counterpart of the FDTD Ez data selector. It generates the mutually exclusive `calc_Hy_en_o`, `calc_Ez_en_o` and `calc_src_en_o` strobes, the cell address, and the step count that drive the 1-D FDTD datapath over a programmed number of time steps. In each time step it sweeps all Hy cells, then all Ez cells, then loads the source at one fixed cell. It sits between the plugin register interface (start/abort/step count) and the FDTD update datapath, and produces the `{calc_Ez_en, calc_src_en}` pair that the Ez selector consumes.

## Interface
- `CELL_NUM`, 200: number of grid cells per sweep; must be ≥ 2.
- `SRC_POS`, 100: source cell index, 0 ≤ `SRC_POS` < `CELL_NUM`.
- `ADDR_WIDTH`, 8: cell address width; `2^ADDR_WIDTH` ≥ `CELL_NUM`.
- `STEP_WIDTH`, 16: time-step counter width.
- `CLK` input 1: clock; all logic on the rising edge.
- `RST` input 1: reset, synchronous, active-high.
- `start_i` input 1: single-cycle start request.
- `abort_i` input 1: stop the run; highest priority after `RST`.
- `step_num_i` input `STEP_WIDTH`: number of time steps; sampled on an accepted start.
- `calc_ready_i` input 1: datapath accepts the current cell when high.
- `calc_Hy_en_o` output 1: Hy update strobe.
- `calc_Ez_en_o` output 1: Ez update strobe (selector `2'b10`).
- `calc_src_en_o` output 1: source load strobe (selector `2'b01`).
- `cell_addr_o` output `ADDR_WIDTH`: address of the cell being updated.
- `step_cnt_o` output `STEP_WIDTH`: index of the current step, 0-based.
- `busy_o` output 1: run in progress.
- `done_o` output 1: one-cycle pulse at normal completion.

## Operation
- States:
  - IDLE
  - CALC_H: sweeps Hy cells.
  - CALC_E: sweeps Ez cells.
  - LOAD_SRC: one source load.
  - DONE: 1 cycle.
- All outputs are registered. Reset values:
  - all strobes 0
  - `cell_addr_o` 0
  - `step_cnt_o` 0
  - `busy_o` 0
  - `done_o` 0
- Strobe encoding:
  - At most one strobe is high in any cycle.
  - `calc_Ez_en_o` and `calc_src_en_o` are never high together; the selector's `2'b11` code never occurs.
  - In IDLE and DONE all strobes are 0.
- Handshake: a cell is accepted in any cycle where its strobe and `calc_ready_i` are both 1.
  - While `calc_ready_i` = 0, the strobe, `cell_addr_o` and `step_cnt_o` hold their values.
- IDLE:
  - On `start_i` with `step_num_i` ≠ 0: latch `step_num_i`, set `step_cnt_o` = 0, go to CALC_H with address 0, set `busy_o` = 1.
  - On `start_i` with `step_num_i` = 0: go directly to DONE; no strobes are issued.
- CALC_H:
  - `calc_Hy_en_o` = 1. The address steps 0 … `CELL_NUM`-1, one per accept.
  - Accept at `CELL_NUM`-1: go to CALC_E with address 0.
- CALC_E: same sweep with `calc_Ez_en_o` = 1.
  - Accept at `CELL_NUM`-1: go to LOAD_SRC with `cell_addr_o` = `SRC_POS`.
- LOAD_SRC: `calc_src_en_o` = 1 for exactly one accepted cycle. On accept:
  - If `step_cnt_o` = latched N-1: go to DONE.
  - Otherwise: increment `step_cnt_o` and go to CALC_H with address 0.
- DONE: `done_o` = 1 and `busy_o` = 0 for one cycle, then IDLE. `step_cnt_o` keeps its last value until the next start.
- `start_i` while `busy_o` = 1 is ignored.
- `abort_i` = 1 in any state other than IDLE:
  - next cycle goes to IDLE, all strobes 0, `busy_o` 0, no `done_o`.
  - `step_cnt_o` and `cell_addr_o` clear to 0.
- `abort_i` and `start_i` in the same IDLE cycle: start is ignored.
- `RST` mid-run: next cycle all outputs are at their reset values, regardless of state.
- Counters never wrap:
  - the address stops at `CELL_NUM`-1;
  - `step_cnt_o` maxes at N-1;
  - `step_num_i` = `2^STEP_WIDTH`-1 is legal.

## Timing
- Start accepted at cycle t: first `calc_Hy_en_o` at t+1 with address 0.
- With `calc_ready_i` held at 1:
  - one step takes 2·`CELL_NUM`+1 cycles;
  - sweeps run back-to-back with no idle cycles between phases or steps;
  - the last source accept is at t+N·(2·`CELL_NUM`+1);
  - `done_o` fires at t+N·(2·`CELL_NUM`+1)+1.
- Each cycle with `calc_ready_i` = 0 while a strobe is high adds exactly one cycle of latency.
- `busy_o` rises at t+1 and falls in the `done_o` cycle.
- With `step_num_i` = 0: `done_o` at t+1 and `busy_o` stays 0.

## Test plan
- Run with `CELL_NUM`=8, `SRC_POS`=3, N=2, `calc_ready_i`=1, start at t=10. Required response:
  - Hy addresses 0–7 at cycles 11–18, Ez 0–7 at 19–26, src at address 3 in cycle 27;
  - step 1 repeats this at 28–44;
  - `done_o` at 45; the strobes are never 2 high at once.
- Same run with `calc_ready_i` low for cycles 14–16: address 3 is held at 14–16 with `calc_Hy_en_o` held high; `done_o` moves to cycle 48.
- Start with `step_num_i`=0 at t=5: `done_o` at 6, no strobes, `busy_o` never 1.
- `abort_i` at the cycle Ez address = 5 in step 0: next cycle all strobes 0, `busy_o`=0, `cell_addr_o`=0; no `done_o`; a restart then behaves as in the first scenario.
- `start_i` pulsed mid-run with a different `step_num_i`: ignored; the original N=2 completes with unchanged timing.
- `RST` asserted during LOAD_SRC: all outputs are 0 on the next cycle; a following start runs normally.
